// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

  // Transmitter control states: wait for data, fetch a byte, shift it out
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } tx_state_e;

  // Frame lengths in bits: start + 8 data + stop, optionally plus parity
  localparam int FRAME_BITS_BASE   = 10;
  localparam int FRAME_BITS_PARITY = 11;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_BASE;
`endif

  // The start bit goes straight to the line at load time, so the shift
  // register only needs to hold the bits that follow it
  localparam int SHIFT_BITS = FRAME_BITS - 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that buffers data waiting to be serialised by uart_tx_buf.
// Pointers wrap naturally because FIFO_DEPTH is a power of two; the
// occupancy is kept in its own register so full/empty never depend on
// pointer comparison.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          pop,
  output logic [7:0]                    data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign data    = mem[rd_ptr];

  // Storage array; only written by accepted pushes, never needs clearing
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count where it was
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: bytes are queued in uart_tx_fifo and sent as
// start / 8 data bits LSB first / stop frames, each bit BAUD_PERIOD+1 clocks.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   BAUD_PERIOD,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          TX,
  output logic                          busy,
  output logic                          tx_done
);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic                  pop;
  logic                  empty;
  logic [7:0]            fifo_data;
  logic [SHIFT_BITS-1:0] shreg;
  logic [SHIFT_BITS-1:0] frame_tail;
  logic [31:0]           baud_q;
  logic [31:0]           baud_cnt;
  logic [3:0]            bit_cnt;
  logic                  tx_q;
  logic                  bit_end;
  logic                  frame_end;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .data      (fifo_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

`ifdef UART_TX_PARITY_EN
  assign frame_tail = {1'b1, ^fifo_data, fifo_data};
`else
  assign frame_tail = {1'b1, fifo_data};
`endif

  assign bit_end   = (baud_cnt == baud_q);
  assign frame_end = bit_end && (bit_cnt == 4'(FRAME_BITS - 1));
  assign TX        = tx_q;

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the pop strobe and status outputs; a finished frame
  // goes straight to LOAD when more bytes are waiting
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_done = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        pop     = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (frame_end) begin
          tx_done = 1'b1;
          state_d = empty ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial datapath: latch the bit time and frame at load, then hold each
  // bit for baud_q+1 clocks before shifting the next one onto the line
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= 1'b1;
      shreg    <= '0;
      baud_q   <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          tx_q     <= 1'b0;
          shreg    <= frame_tail;
          baud_q   <= BAUD_PERIOD;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        SEND: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (frame_end) begin
              tx_q <= 1'b1;
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        default: begin
          tx_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
